// File: rtl/seq_mult_if.sv
// Operator-side bundle for seq_mult_unit:
// button/switch inputs and register readback.
interface seq_mult_if #(
  parameter int WIDTH = 8
);
  logic             ClearA_LoadB;
  logic             Execute;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Xval;
  logic             Busy;
  logic             Done;

  modport master (
    output ClearA_LoadB, Execute, Din,
    input  Aval, Bval, Xval, Busy, Done
  );

  modport slave (
    input  ClearA_LoadB, Execute, Din,
    output Aval, Bval, Xval, Busy, Done
  );
endinterface

// File: rtl/seq_mult_unit.sv
// Signed add-shift multiplier, product in {A,B}.
// SEQ_MULT_FAST_EN merges ADD/SHIFT into one CALC state.
module seq_mult_unit #(
  parameter int WIDTH = 8
) (
  input logic       Clk,
  input logic       Reset,
  seq_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

`ifdef SEQ_MULT_FAST_EN
  typedef enum logic [1:0] {
    IDLE, CALC, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, ADD, SHIFT, DONE
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] a, b, s;
  logic             x;
  logic [CW-1:0]    cnt;
  logic             busy, done;
  logic             last;
  logic [WIDTH:0]   sum;

  assign last = (cnt == CW'(WIDTH - 1));

  // Top multiplier bit carries negative weight.
  always_comb begin
    sum = '0;
    if (last)
      sum = {a[WIDTH-1], a} - {s[WIDTH-1], s};
    else
      sum = {a[WIDTH-1], a} + {s[WIDTH-1], s};
  end

`ifdef SEQ_MULT_FAST_EN
  logic             nx;
  logic [WIDTH-1:0] na;

  always_comb begin
    nx = x;
    na = a;
    if (b[0]) begin
      nx = sum[WIDTH];
      na = sum[WIDTH-1:0];
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      s     <= '0;
      x     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.ClearA_LoadB) begin
            b <= bus.Din;
            a <= '0;
            x <= 1'b0;
          end else if (!bus.Execute) begin
            s     <= bus.Din;
            a     <= '0;
            x     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef SEQ_MULT_FAST_EN
            state <= CALC;
`else
            state <= ADD;
`endif
          end
        end
`ifdef SEQ_MULT_FAST_EN
        CALC: begin
          x   <= nx;
          a   <= {nx, na[WIDTH-1:1]};
          b   <= {na[0], b[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
`else
        ADD: begin
          if (b[0]) begin
            a <= sum[WIDTH-1:0];
            x <= sum[WIDTH];
          end
          state <= SHIFT;
        end
        SHIFT: begin
          a   <= {x, a[WIDTH-1:1]};
          b   <= {a[0], b[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ADD;
          end
        end
`endif
        DONE: begin
          if (bus.Execute) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Aval = a;
  assign bus.Bval = b;
  assign bus.Xval = x;
  assign bus.Busy = busy;
  assign bus.Done = done;
endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit, WIDTH=8.
// Expected products worked out by hand.
module tb_seq_mult_unit;
  localparam int W = 8;
`ifdef SEQ_MULT_FAST_EN
  localparam int LAT = W;
`else
  localparam int LAT = 2 * W;
`endif

  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult_unit #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] d);
    bus.Din          = d;
    bus.ClearA_LoadB = 1'b0;
    tick();
    bus.ClearA_LoadB = 1'b1;
  endtask

  task automatic run(input string tag,
                     input logic [W-1:0] d);
    bus.Din     = d;
    bus.Execute = 1'b0;
    tick();
    check({tag, "_busy"}, 32'(bus.Busy), 32'd1);
    repeat (LAT - 1) tick();
    check({tag, "_early"}, 32'(bus.Done), 32'd0);
    tick();
    check({tag, "_done"}, 32'(bus.Done), 32'd1);
  endtask

  task automatic result(input string tag,
                        input logic [W-1:0] ea,
                        input logic [W-1:0] eb,
                        input logic ex);
    check({tag, "_A"}, 32'(bus.Aval), 32'(ea));
    check({tag, "_B"}, 32'(bus.Bval), 32'(eb));
    check({tag, "_X"}, 32'(bus.Xval), 32'(ex));
  endtask

  task automatic release_exec();
    bus.Execute = 1'b1;
    tick();
    check("to_idle", 32'(bus.Done), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b0;
    bus.ClearA_LoadB = 1'b1;
    bus.Execute      = 1'b1;
    bus.Din          = '0;
    repeat (3) tick();
    result("rst", 8'h00, 8'h00, 1'b0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    Reset = 1'b1;
    tick();

    // 7 * 59 = 413
    load(8'h3B);
    check("load_B", 32'(bus.Bval), 32'h3B);
    run("m1", 8'h07);
    result("m1", 8'h01, 8'h9D, 1'b0);
    release_exec();

    // -3 * 5 = -15
    load(8'h05);
    run("m2", 8'hFD);
    result("m2", 8'hFF, 8'hF1, 1'b1);
    release_exec();

    // -128 * -128 = 16384
    load(8'h80);
    run("m3", 8'h80);
    result("m3", 8'h40, 8'h00, 1'b0);
    repeat (40) tick();
    check("hold_done", 32'(bus.Done), 32'd1);
    check("hold_busy", 32'(bus.Busy), 32'd0);
    result("hold", 8'h40, 8'h00, 1'b0);
    release_exec();

    // Chained: 2 * B(0x00) = 0
    run("chain", 8'h02);
    result("chain", 8'h00, 8'h00, 1'b0);
    release_exec();

    // Asynchronous reset five cycles into a run
    load(8'h33);
    bus.Din     = 8'h11;
    bus.Execute = 1'b0;
    tick();
    repeat (4) tick();
    check("pre_rst_busy", 32'(bus.Busy), 32'd1);
    Reset = 1'b0;
    #1;
    result("arst", 8'h00, 8'h00, 1'b0);
    check("arst_busy", 32'(bus.Busy), 32'd0);
    check("arst_done", 32'(bus.Done), 32'd0);
    bus.Execute = 1'b1;
    tick();
    Reset = 1'b1;
    tick();
    check("post_rst_busy", 32'(bus.Busy), 32'd0);
    check("post_rst_done", 32'(bus.Done), 32'd0);

    // 12 * -10 = -120
    load(8'hF6);
    run("m4", 8'h0C);
    result("m4", 8'hFF, 8'h88, 1'b1);
    release_exec();

    // Load beats Execute in the same cycle
    bus.Din          = 8'h12;
    bus.ClearA_LoadB = 1'b0;
    bus.Execute      = 1'b0;
    tick();
    bus.ClearA_LoadB = 1'b1;
    bus.Execute      = 1'b1;
    check("prio_B", 32'(bus.Bval), 32'h12);
    check("prio_busy", 32'(bus.Busy), 32'd0);
    tick();
    check("prio_idle", 32'(bus.Busy), 32'd0);

    // Load and Din ignored while busy: 5 * 0x12 = 90
    bus.Din     = 8'h05;
    bus.Execute = 1'b0;
    tick();
    bus.Din          = 8'hAA;
    bus.ClearA_LoadB = 1'b0;
    repeat (3) tick();
    bus.ClearA_LoadB = 1'b1;
    repeat (LAT - 3) tick();
    check("ign_done", 32'(bus.Done), 32'd1);
    result("ign", 8'h00, 8'h5A, 1'b0);
    release_exec();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
